// File: rtl/multi_dispatcher_pkg.sv
// Shared word formats, option codes and field helpers for the multi-channel dispatcher.
// A worker result is {opt, dest_addr, color, data}; a packet request appends one more data word.
package multi_dispatcher_pkg;

  localparam int OPT_W                = 3;
  localparam int ADDR_W               = 16;
  localparam int COLOR_W              = 16;
  localparam int DATA_W               = 32;
  localparam int WORKER_RESULT_WIDTH  = OPT_W + ADDR_W + COLOR_W + DATA_W;
  localparam int PACKET_REQUEST_WIDTH = WORKER_RESULT_WIDTH + DATA_W;

  typedef enum logic [OPT_W-1:0] {
    DEST_OPTION_NOP   = 3'd0,
    DEST_OPTION_END   = 3'd1,
    DEST_OPTION_EXEC  = 3'd2,
    DEST_OPTION_ONE   = 3'd3,
    DEST_OPTION_LEFT  = 3'd4,
    DEST_OPTION_RIGHT = 3'd5
  } dest_option_e;

  function automatic logic [OPT_W-1:0] wr_opt(input logic [WORKER_RESULT_WIDTH-1:0] w);
    return w[WORKER_RESULT_WIDTH-1 -: OPT_W];
  endfunction

  function automatic logic [ADDR_W-1:0] wr_dest(input logic [WORKER_RESULT_WIDTH-1:0] w);
    return w[COLOR_W+DATA_W +: ADDR_W];
  endfunction

  function automatic logic [COLOR_W-1:0] wr_color(input logic [WORKER_RESULT_WIDTH-1:0] w);
    return w[DATA_W +: COLOR_W];
  endfunction

  function automatic logic [DATA_W-1:0] wr_data(input logic [WORKER_RESULT_WIDTH-1:0] w);
    return w[DATA_W-1:0];
  endfunction

  function automatic logic [WORKER_RESULT_WIDTH-1:0] make_worker_result(
      input logic [OPT_W-1:0] opt, input logic [ADDR_W-1:0] dest,
      input logic [COLOR_W-1:0] color, input logic [DATA_W-1:0] data);
    return {opt, dest, color, data};
  endfunction

  function automatic logic [PACKET_REQUEST_WIDTH-1:0] make_packet_request(
      input logic [OPT_W-1:0] opt, input logic [ADDR_W-1:0] dest,
      input logic [COLOR_W-1:0] color, input logic [DATA_W-1:0] data,
      input logic [DATA_W-1:0] data2);
    return {opt, dest, color, data, data2};
  endfunction

endpackage

// File: rtl/multi_dispatcher_fifo.sv
// Synchronous FIFO with valid/ready on both sides; head data reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             i_push_valid,
  output logic             o_push_ready,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_pop_valid,
  input  logic             i_pop_ready,
  output logic [WIDTH-1:0] o_pop_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Full blocks pushes even when a pop happens in the same cycle.
  assign o_push_ready = (r_count != CW'(DEPTH));
  assign o_pop_valid  = (r_count != {CW{1'b0}});
  assign o_pop_data   = o_pop_valid ? r_mem[r_rd_ptr] : {WIDTH{1'b0}};
  assign w_push       = i_push_valid & o_push_ready;
  assign w_pop        = i_pop_ready & o_pop_valid;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= {WIDTH{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/multi_dispatcher.sv
// Round-robin merge of NUM_IN worker-result channels into a packet-request FIFO and a loopback FIFO,
// with a sticky END-token counter.
module multi_dispatcher
  import multi_dispatcher_pkg::*;
#(
  parameter int NUM_IN        = 4,
  parameter int PR_FIFO_DEPTH = 4,
  parameter int WR_FIFO_DEPTH = 4,
  parameter int END_COUNT     = 1
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,
  input  logic [NUM_IN-1:0]                     RECEIVE_WR_VALID,
  input  logic [NUM_IN*WORKER_RESULT_WIDTH-1:0] RECEIVE_WR_DATA,
  output logic [NUM_IN-1:0]                     RECEIVE_WR_READY,
  output logic                                  SEND_WR_VALID,
  output logic [WORKER_RESULT_WIDTH-1:0]        SEND_WR_DATA,
  input  logic                                  SEND_WR_READY,
  output logic                                  SEND_PR_VALID,
  output logic [PACKET_REQUEST_WIDTH-1:0]       SEND_PR_DATA,
  input  logic                                  SEND_PR_READY,
  output logic                                  EXECUTION_END
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int ECW   = $clog2(END_COUNT + 1);

  logic [PTR_W-1:0]                r_rr_ptr;
  logic [ECW-1:0]                  r_end_cnt;
  logic                            r_exec_end;
  logic [PTR_W-1:0]                w_grant_idx;
  logic                            w_found;
  logic [WORKER_RESULT_WIDTH-1:0]  w_grant_data;
  logic [OPT_W-1:0]                w_opt;
  logic                            w_accept;
  logic                            w_pr_push;
  logic                            w_wr_push;
  logic                            w_end_hit;
  logic                            w_pr_ready;
  logic                            w_wr_ready;
  logic [PACKET_REQUEST_WIDTH-1:0] w_pr_data;

  // First valid channel at or after the pointer, wrapping around.
  always_comb begin : p_arb
    int v_idx;
    v_idx       = 0;
    w_found     = 1'b0;
    w_grant_idx = r_rr_ptr;
    for (int k = 0; k < NUM_IN; k++) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= NUM_IN) v_idx = v_idx - NUM_IN;
      else v_idx = v_idx;
      if (!w_found && RECEIVE_WR_VALID[PTR_W'(v_idx)]) begin
        w_found     = 1'b1;
        w_grant_idx = PTR_W'(v_idx);
      end else begin
        w_grant_idx = w_grant_idx;
      end
    end
  end

  always_comb begin
    w_grant_data = {WORKER_RESULT_WIDTH{1'b0}};
    for (int k = 0; k < NUM_IN; k++) begin
      if (w_grant_idx == PTR_W'(k)) w_grant_data = RECEIVE_WR_DATA[k*WORKER_RESULT_WIDTH +: WORKER_RESULT_WIDTH];
      else w_grant_data = w_grant_data;
    end
  end

  assign w_opt = wr_opt(w_grant_data);

  // A blocked grantee stalls every channel so the pointer never skips it.
  always_comb begin
    w_accept  = 1'b0;
    w_pr_push = 1'b0;
    w_wr_push = 1'b0;
    w_end_hit = 1'b0;
    if (w_found && RST_N) begin
      case (w_opt)
        DEST_OPTION_EXEC, DEST_OPTION_ONE: begin
          w_accept  = w_pr_ready;
          w_pr_push = w_pr_ready;
        end
        DEST_OPTION_LEFT, DEST_OPTION_RIGHT: begin
          w_accept  = w_wr_ready;
          w_wr_push = w_wr_ready;
        end
        DEST_OPTION_END: begin
          w_accept  = 1'b1;
          w_end_hit = 1'b1;
        end
        default: w_accept = 1'b1;
      endcase
    end else begin
      w_accept = 1'b0;
    end
  end

  assign RECEIVE_WR_READY = w_accept ? (NUM_IN'(1) << w_grant_idx) : {NUM_IN{1'b0}};
  assign w_pr_data = make_packet_request(w_opt, wr_dest(w_grant_data), wr_color(w_grant_data),
                                         wr_data(w_grant_data), 32'h0000_0000);
  assign EXECUTION_END = r_exec_end;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rr_ptr   <= {PTR_W{1'b0}};
      r_end_cnt  <= {ECW{1'b0}};
      r_exec_end <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rr_ptr <= (w_grant_idx == PTR_W'(NUM_IN - 1)) ? {PTR_W{1'b0}} : w_grant_idx + PTR_W'(1);
      end
      if (w_end_hit && (r_end_cnt != ECW'(END_COUNT))) r_end_cnt <= r_end_cnt + ECW'(1);
      if (w_end_hit && (r_end_cnt == ECW'(END_COUNT - 1))) r_exec_end <= 1'b1;
    end
  end

  sync_fifo #(.WIDTH(PACKET_REQUEST_WIDTH), .DEPTH(PR_FIFO_DEPTH)) u_pr_fifo (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .i_push_valid (w_pr_push),
    .o_push_ready (w_pr_ready),
    .i_push_data  (w_pr_data),
    .o_pop_valid  (SEND_PR_VALID),
    .i_pop_ready  (SEND_PR_READY),
    .o_pop_data   (SEND_PR_DATA)
  );

  sync_fifo #(.WIDTH(WORKER_RESULT_WIDTH), .DEPTH(WR_FIFO_DEPTH)) u_wr_fifo (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .i_push_valid (w_wr_push),
    .o_push_ready (w_wr_ready),
    .i_push_data  (w_grant_data),
    .o_pop_valid  (SEND_WR_VALID),
    .i_pop_ready  (SEND_WR_READY),
    .o_pop_data   (SEND_WR_DATA)
  );

endmodule
